// File: rtl/cache_fill_fsm.sv
// Cache miss fill sequencer: stalls the pipeline, streams an 8-word block from
// main memory into the data array, then writes the tag on the final beat.
module cache_fill_fsm #(
    parameter int WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        fsm_busy,
    output logic        mem_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [2:0]  write_offset,
    output logic [15:0] write_data,
    output logic        write_tag_array,
    output logic [11:0] tag_out
);

    localparam logic [2:0] LAST = 3'(WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [11:0] base;
    logic [2:0]  issueCnt;
    logic        issuing;
    logic [2:0]  rxCnt;

    // Block offset bits of the miss address play no part in the fill.
    logic unusedAddrBits;
    assign unusedAddrBits = ^miss_address[3:0];

    // Memory handshake: mem_en is a fire-and-forget request with no ready;
    // memory_data_valid marks one returned beat, and beats come back in request order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base     <= 12'd0;
            issueCnt <= 3'd0;
            issuing  <= 1'b0;
            rxCnt    <= 3'd0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base     <= miss_address[15:4];
                        issueCnt <= 3'd0;
                        issuing  <= 1'b1;
                        rxCnt    <= 3'd0;
                    end
                end
                FILL: begin
                    if (issuing) begin
                        if (issueCnt == LAST) begin
                            issuing <= 1'b0;
                        end else begin
                            issueCnt <= issueCnt + 3'd1;
                        end
                    end
                    // Wraps to 0 on the last beat, leaving it clean for the next fill.
                    if (memory_data_valid) begin
                        rxCnt <= rxCnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nextState        = state;
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        memory_address   = 16'd0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        case (state)
            IDLE: begin
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    nextState = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                mem_en   = issuing;
                if (issuing) begin
                    memory_address = {base, issueCnt, 1'b0};
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    if (rxCnt == LAST) begin
                        write_tag_array = 1'b1;
                        nextState       = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign write_offset = rxCnt;
    assign write_data   = memory_data;
    assign tag_out      = base;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a fixed-latency, in-order memory model.
module tb_cache_fill_fsm;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'd0;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = 16'd0;
    logic        fsm_busy;
    logic        mem_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  write_offset;
    logic [15:0] write_data;
    logic        write_tag_array;
    logic [11:0] tag_out;

    cache_fill_fsm #(.WORDS(8)) dut (
        .clk(clk), .rst(rst),
        .miss_detected(miss_detected), .miss_address(miss_address),
        .memory_data_valid(memory_data_valid), .memory_data(memory_data),
        .fsm_busy(fsm_busy), .mem_en(mem_en), .memory_address(memory_address),
        .write_data_array(write_data_array), .write_offset(write_offset),
        .write_data(write_data), .write_tag_array(write_tag_array), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [15:0] d;
    } beat_t;

    beat_t memQ[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    int    stallFrom = 8;
    int    stallLen = 0;
    logic  forceValid = 1'b0;

    logic        s_busy, s_memEn, s_wd, s_wt;
    logic [15:0] s_addr, s_wdata;
    logic [2:0]  s_off;
    logic [11:0] s_tag;

    // One clock cycle: drive memory beats, sample outputs mid-cycle, record requests.
    task automatic step();
        memory_data_valid = forceValid;
        memory_data = 16'd0;
        if (memQ.size() > 0 && memQ[0].t == cyc) begin
            memory_data_valid = 1'b1;
            memory_data = memQ[0].d;
            void'(memQ.pop_front());
        end
        #4;
        s_busy = fsm_busy; s_memEn = mem_en; s_addr = memory_address;
        s_wd = write_data_array; s_off = write_offset; s_wdata = write_data;
        s_wt = write_tag_array; s_tag = tag_out;
        if (s_memEn) begin
            int k;
            k = int'(s_addr[3:1]);
            memQ.push_back('{cyc + L + ((k >= stallFrom) ? stallLen : 0), 16'hA000 + 16'(k)});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_fill(input logic [15:0] a, input bit noise,
                            output int busyCyc, output int nWr, output int nTag, output int nReq,
                            output bit orderOk, output bit addrOk, output bit timedOut,
                            output logic [11:0] tagSeen);
        busyCyc = 0; nWr = 0; nTag = 0; nReq = 0;
        orderOk = 1'b1; addrOk = 1'b1; timedOut = 1'b1; tagSeen = 12'd0;
        miss_detected = 1'b1;
        miss_address = a;
        step();
        if (s_busy) busyCyc++;
        for (int j = 1; j < 60; j++) begin
            miss_detected = noise && (j < 10) && (j % 2 == 1);
            miss_address = noise ? 16'hFFFF : a;
            step();
            if (!s_busy) begin
                timedOut = 1'b0;
                break;
            end
            busyCyc++;
            if (s_memEn) begin
                if (s_addr[15:4] !== a[15:4] || s_addr[3:1] !== 3'(nReq) || s_addr[0] !== 1'b0)
                    addrOk = 1'b0;
                nReq++;
            end
            if (s_wd) begin
                if (s_off !== 3'(nWr) || s_wdata !== (16'hA000 + 16'(nWr))) orderOk = 1'b0;
                nWr++;
            end
            if (s_wt) begin
                nTag++;
                tagSeen = s_tag;
            end
        end
        miss_detected = 1'b0;
        miss_address = 16'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", s_busy); end
        checks++; if (s_memEn !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%0b exp=0", s_memEn); end
        checks++; if (s_addr !== 16'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", s_addr); end
        checks++; if (s_wd !== 1'b0) begin failures++; $display("FAIL reset_wda got=%0b exp=0", s_wd); end
        checks++; if (s_wt !== 1'b0) begin failures++; $display("FAIL reset_wta got=%0b exp=0", s_wt); end
        checks++; if (s_off !== 3'd0) begin failures++; $display("FAIL reset_offset got=%0d exp=0", s_off); end
        checks++; if (s_tag !== 12'd0) begin failures++; $display("FAIL reset_tag got=%0h exp=0", s_tag); end
    endtask

    task automatic test_basic_fill();
        logic        expBusy, expEn, expWd, expWt;
        logic [15:0] expAddr;
        logic [2:0]  expOff;
        for (int j = 0; j <= 13; j++) begin
            miss_detected = (j == 0);
            miss_address = 16'h1236;
            step();
            expBusy = (j <= 12);
            expEn = (j >= 1 && j <= 8);
            expAddr = expEn ? 16'h1230 + 16'(2 * (j - 1)) : 16'd0;
            expWd = (j >= 5 && j <= 12);
            expOff = expWd ? 3'(j - 5) : 3'd0;
            expWt = (j == 12);
            checks++; if (s_busy !== expBusy) begin failures++; $display("FAIL basic_busy j=%0d got=%0b exp=%0b", j, s_busy, expBusy); end
            checks++; if (s_memEn !== expEn) begin failures++; $display("FAIL basic_mem_en j=%0d got=%0b exp=%0b", j, s_memEn, expEn); end
            checks++; if (s_addr !== expAddr) begin failures++; $display("FAIL basic_addr j=%0d got=%0h exp=%0h", j, s_addr, expAddr); end
            checks++; if (s_wd !== expWd) begin failures++; $display("FAIL basic_wda j=%0d got=%0b exp=%0b", j, s_wd, expWd); end
            checks++; if (s_off !== expOff) begin failures++; $display("FAIL basic_offset j=%0d got=%0d exp=%0d", j, s_off, expOff); end
            checks++; if (s_wt !== expWt) begin failures++; $display("FAIL basic_wta j=%0d got=%0b exp=%0b", j, s_wt, expWt); end
            if (expWd) begin
                checks++; if (s_wdata !== 16'hA000 + 16'(j - 5)) begin failures++; $display("FAIL basic_wdata j=%0d got=%0h exp=%0h", j, s_wdata, 16'hA000 + 16'(j - 5)); end
            end
            if (j >= 1) begin
                checks++; if (s_tag !== 12'h123) begin failures++; $display("FAIL basic_tag j=%0d got=%0h exp=123", j, s_tag); end
            end
        end
        miss_detected = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j <= 26; j++) begin
            miss_detected = (j == 0) || (j == 13);
            miss_address = (j == 13) ? 16'h4F00 : 16'h1236;
            step();
            if (j == 13) begin
                checks++; if (s_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_at_miss got=%0b exp=1", s_busy); end
                checks++; if (s_memEn !== 1'b0) begin failures++; $display("FAIL b2b_en_at_miss got=%0b exp=0", s_memEn); end
            end
            if (j >= 13 && j <= 17) begin
                checks++; if (s_wd !== 1'b0) begin failures++; $display("FAIL b2b_gap_write j=%0d got=%0b exp=0", j, s_wd); end
            end
            if (j == 14) begin
                checks++; if (s_memEn !== 1'b1 || s_addr !== 16'h4F00) begin failures++; $display("FAIL b2b_first_req en=%0b addr=%0h exp en=1 addr=4f00", s_memEn, s_addr); end
            end
            if (j == 25) begin
                checks++; if (s_wt !== 1'b1 || s_tag !== 12'h4F0) begin failures++; $display("FAIL b2b_tag wta=%0b tag=%0h exp wta=1 tag=4f0", s_wt, s_tag); end
            end
            if (j == 26) begin
                checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%0b exp=0", s_busy); end
            end
        end
        miss_detected = 1'b0;
    endtask

    task automatic test_stalled_memory();
        int busyCyc, nWr, nTag, nReq;
        bit orderOk, addrOk, timedOut;
        logic [11:0] tagSeen;
        stallFrom = 4;
        stallLen = 3;
        run_fill(16'h5678, 1'b0, busyCyc, nWr, nTag, nReq, orderOk, addrOk, timedOut, tagSeen);
        stallFrom = 8;
        stallLen = 0;
        checks++; if (timedOut) begin failures++; $display("FAIL stall_timeout got=1 exp=0"); end
        checks++; if (busyCyc != 16) begin failures++; $display("FAIL stall_busy_cycles got=%0d exp=16", busyCyc); end
        checks++; if (nWr != 8) begin failures++; $display("FAIL stall_writes got=%0d exp=8", nWr); end
        checks++; if (nTag != 1) begin failures++; $display("FAIL stall_tag_writes got=%0d exp=1", nTag); end
        checks++; if (!orderOk) begin failures++; $display("FAIL stall_order got=0 exp=1"); end
        checks++; if (tagSeen !== 12'h567) begin failures++; $display("FAIL stall_tag got=%0h exp=567", tagSeen); end
    endtask

    task automatic test_miss_during_fill();
        int busyCyc, nWr, nTag, nReq;
        bit orderOk, addrOk, timedOut;
        logic [11:0] tagSeen;
        run_fill(16'h2468, 1'b1, busyCyc, nWr, nTag, nReq, orderOk, addrOk, timedOut, tagSeen);
        checks++; if (timedOut) begin failures++; $display("FAIL noise_timeout got=1 exp=0"); end
        checks++; if (nReq != 8) begin failures++; $display("FAIL noise_requests got=%0d exp=8", nReq); end
        checks++; if (!addrOk) begin failures++; $display("FAIL noise_addresses got=0 exp=1"); end
        checks++; if (tagSeen !== 12'h246) begin failures++; $display("FAIL noise_tag got=%0h exp=246", tagSeen); end
        checks++; if (busyCyc != 13 || nWr != 8 || nTag != 1) begin failures++; $display("FAIL noise_counts busy=%0d wr=%0d tag=%0d exp 13/8/1", busyCyc, nWr, nTag); end
    endtask

    task automatic test_reset_mid_fill();
        int lateWr = 0;
        int lateTag = 0;
        for (int j = 0; j <= 16; j++) begin
            miss_detected = (j == 0);
            miss_address = 16'h3450;
            rst = (j == 7);
            step();
            if (j == 7) begin
                checks++; if (s_wd !== 1'b1 || s_off !== 3'd2) begin failures++; $display("FAIL rstmid_beat2 wda=%0b off=%0d exp wda=1 off=2", s_wd, s_off); end
            end
            if (j == 8) begin
                checks++; if (s_busy !== 1'b0 || s_memEn !== 1'b0 || s_addr !== 16'd0) begin failures++; $display("FAIL rstmid_idle busy=%0b en=%0b addr=%0h exp 0/0/0", s_busy, s_memEn, s_addr); end
                checks++; if (s_off !== 3'd0 || s_tag !== 12'd0) begin failures++; $display("FAIL rstmid_regs off=%0d tag=%0h exp 0/0", s_off, s_tag); end
            end
            if (j >= 8) begin
                if (s_wd) lateWr++;
                if (s_wt) lateTag++;
            end
        end
        rst = 1'b0;
        miss_detected = 1'b0;
        checks++; if (lateWr != 0) begin failures++; $display("FAIL rstmid_late_writes got=%0d exp=0", lateWr); end
        checks++; if (lateTag != 0) begin failures++; $display("FAIL rstmid_tag_writes got=%0d exp=0", lateTag); end
    endtask

    task automatic test_idle_noise();
        int busyCyc, nWr, nTag, nReq;
        bit orderOk, addrOk, timedOut;
        logic [11:0] tagSeen;
        for (int j = 0; j < 8; j++) begin
            forceValid = (j % 2 == 0);
            step();
            checks++; if (s_wd !== 1'b0 || s_busy !== 1'b0 || s_memEn !== 1'b0 || s_wt !== 1'b0) begin failures++; $display("FAIL idle_noise j=%0d wda=%0b busy=%0b en=%0b wta=%0b exp all 0", j, s_wd, s_busy, s_memEn, s_wt); end
        end
        forceValid = 1'b0;
        run_fill(16'h1000, 1'b0, busyCyc, nWr, nTag, nReq, orderOk, addrOk, timedOut, tagSeen);
        checks++; if (timedOut || !orderOk || nWr != 8 || nTag != 1) begin failures++; $display("FAIL idle_then_fill timeout=%0b order=%0b wr=%0d tag=%0d exp 0/1/8/1", timedOut, orderOk, nWr, nTag); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic_fill();
        test_back_to_back();
        test_stalled_memory();
        test_miss_during_fill();
        test_reset_mid_fill();
        test_idle_noise();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
